// File: rtl/pipe_pkg.sv
// Shared write-back pipeline types: default widths, the zero-register constant
// and the destination tag carried by both stage registers and the forwarding unit.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              RegWre;
    logic [REG_AW-1:0] WriteReg;
    logic              MemToReg;
  } wb_tag_t;

  localparam wb_tag_t TAG_BUBBLE = '{RegWre: 1'b0, WriteReg: REG_ZERO, MemToReg: 1'b0};

endpackage

// File: rtl/wb_stage_reg.sv
// One write-back pipeline stage register: destination tag plus data word.
// Bubble has priority over Hold so a flush lands even while the pipe is frozen.
module wb_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              Bubble,
  input  wb_tag_t           tagIn,
  input  logic [DATA_W-1:0] dataIn,
  output wb_tag_t           tagOut,
  output logic [DATA_W-1:0] dataOut
);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tagOut  <= TAG_BUBBLE;
      dataOut <= '0;
    end else if (Bubble) begin
      tagOut  <= TAG_BUBBLE;
      dataOut <= '0;
    end else if (!Hold) begin
      tagOut  <= tagIn;
      dataOut <= dataIn;
    end
  end

endmodule

// File: rtl/wb_dest_pipe.sv
// EX/MEM and MEM/WB write-back tag pipeline with retire counter and load-use detect.
// Optional feature: define LOAD_USE_DETECT_EN to build the load-use stall comparators.
module wb_dest_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              Flush,
  input  logic              EX_RegWre,
  input  logic              EX_MemToReg,
  input  logic [REG_AW-1:0] EX_WriteReg,
  input  logic [DATA_W-1:0] EX_Result,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic [DATA_W-1:0] MEM_ReadData,
  output logic              MEM_RegWre,
  output logic [REG_AW-1:0] MEM_WriteReg,
  output logic              MEM_MemToReg,
  output logic [DATA_W-1:0] MEM_ALUResult,
  output logic              WB_RegWre,
  output logic [REG_AW-1:0] WB_WriteReg,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic              LoadUse_Stall,
  output logic [CNT_W-1:0]  WB_Count
);

  wb_tag_t           exTag;
  wb_tag_t           memTag;
  wb_tag_t           wbTag;
  logic [DATA_W-1:0] wbDataIn;

  // Writes to register 0 are dropped here so no downstream consumer sees them.
  always_comb begin
    exTag          = TAG_BUBBLE;
    exTag.RegWre   = EX_RegWre && (EX_WriteReg != REG_ZERO);
    exTag.WriteReg = EX_WriteReg;
    exTag.MemToReg = EX_MemToReg;
  end

  wb_stage_reg #(.DATA_W(DATA_W)) exMemReg (
    .CLK     (CLK),
    .Reset   (Reset),
    .Hold    (Hold),
    .Bubble  (Flush),
    .tagIn   (exTag),
    .dataIn  (EX_Result),
    .tagOut  (memTag),
    .dataOut (MEM_ALUResult)
  );

  assign wbDataIn = memTag.MemToReg ? MEM_ReadData : MEM_ALUResult;

  wb_stage_reg #(.DATA_W(DATA_W)) memWbReg (
    .CLK     (CLK),
    .Reset   (Reset),
    .Hold    (Hold),
    .Bubble  (1'b0),
    .tagIn   (memTag),
    .dataIn  (wbDataIn),
    .tagOut  (wbTag),
    .dataOut (WB_WriteData)
  );

  assign MEM_RegWre   = memTag.RegWre;
  assign MEM_WriteReg = memTag.WriteReg;
  assign MEM_MemToReg = memTag.MemToReg;
  assign WB_RegWre    = wbTag.RegWre;
  assign WB_WriteReg  = wbTag.WriteReg;

  // Counts the write leaving WB on each advancing edge; sticks at all-ones.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      WB_Count <= '0;
    end else if (WB_RegWre && !Hold && (WB_Count != {CNT_W{1'b1}})) begin
      WB_Count <= WB_Count + 1'b1;
    end
  end

`ifdef LOAD_USE_DETECT_EN
  assign LoadUse_Stall = EX_RegWre && EX_MemToReg && (EX_WriteReg != REG_ZERO) &&
                         ((ID_rs == EX_WriteReg) || (ID_rt == EX_WriteReg));
`else
  // Hazard handling lives outside this block in this build.
  logic unusedIdRegs;
  assign unusedIdRegs  = ^{ID_rs, ID_rt};
  assign LoadUse_Stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed self-checking bench for wb_dest_pipe; one task per scenario.
// Load-use expectations follow whether LOAD_USE_DETECT_EN is defined.
module tb_wb_dest_pipe;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Hold, Flush;
  logic        EX_RegWre, EX_MemToReg;
  logic [4:0]  EX_WriteReg, ID_rs, ID_rt;
  logic [31:0] EX_Result, MEM_ReadData;
  logic        MEM_RegWre, MEM_MemToReg, WB_RegWre, LoadUse_Stall;
  logic [4:0]  MEM_WriteReg, WB_WriteReg;
  logic [31:0] MEM_ALUResult, WB_WriteData;
  logic [15:0] WB_Count;

  int total = 0;
  int bad   = 0;

`ifdef LOAD_USE_DETECT_EN
  localparam logic LU_ON = 1'b1;
`else
  localparam logic LU_ON = 1'b0;
`endif

  wb_dest_pipe dut (
    .CLK(CLK), .Reset(Reset), .Hold(Hold), .Flush(Flush),
    .EX_RegWre(EX_RegWre), .EX_MemToReg(EX_MemToReg), .EX_WriteReg(EX_WriteReg),
    .EX_Result(EX_Result), .ID_rs(ID_rs), .ID_rt(ID_rt), .MEM_ReadData(MEM_ReadData),
    .MEM_RegWre(MEM_RegWre), .MEM_WriteReg(MEM_WriteReg), .MEM_MemToReg(MEM_MemToReg),
    .MEM_ALUResult(MEM_ALUResult), .WB_RegWre(WB_RegWre), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData), .LoadUse_Stall(LoadUse_Stall), .WB_Count(WB_Count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearEx();
    EX_RegWre = 0; EX_MemToReg = 0; EX_WriteReg = 0; EX_Result = 0;
  endtask

  task automatic setEx(input logic [4:0] rd, input logic [31:0] res, input logic ld);
    EX_RegWre = 1; EX_MemToReg = ld; EX_WriteReg = rd; EX_Result = res;
  endtask

  task automatic test_reset();
    Reset = 0; Hold = 0; Flush = 0; clearEx();
    ID_rs = 0; ID_rt = 0; MEM_ReadData = 0;
    #3;
    total++; if ({MEM_RegWre, MEM_WriteReg, MEM_MemToReg} !== 7'd0) begin bad++; $display("[TB] FAIL reset_mem_tag: got %h want 0", {MEM_RegWre, MEM_WriteReg, MEM_MemToReg}); end
    total++; if (MEM_ALUResult !== 32'd0) begin bad++; $display("[TB] FAIL reset_mem_data: got %h want 0", MEM_ALUResult); end
    total++; if ({WB_RegWre, WB_WriteReg} !== 6'd0) begin bad++; $display("[TB] FAIL reset_wb_tag: got %h want 0", {WB_RegWre, WB_WriteReg}); end
    total++; if (WB_WriteData !== 32'd0) begin bad++; $display("[TB] FAIL reset_wb_data: got %h want 0", WB_WriteData); end
    total++; if (WB_Count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count: got %h want 0", WB_Count); end
    total++; if (LoadUse_Stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", LoadUse_Stall); end
    tick();
    Reset = 1;
  endtask

  task automatic test_basic_advance();
    setEx(5'd3, 32'h11, 1'b0);
    tick();
    clearEx();
    total++; if ({MEM_RegWre, MEM_WriteReg} !== {1'b1, 5'd3}) begin bad++; $display("[TB] FAIL basic_mem_tag: got %b/%0d want 1/3", MEM_RegWre, MEM_WriteReg); end
    total++; if (MEM_ALUResult !== 32'h11) begin bad++; $display("[TB] FAIL basic_mem_data: got %h want 11", MEM_ALUResult); end
    tick();
    total++; if ({WB_RegWre, WB_WriteReg} !== {1'b1, 5'd3}) begin bad++; $display("[TB] FAIL basic_wb_tag: got %b/%0d want 1/3", WB_RegWre, WB_WriteReg); end
    total++; if (WB_WriteData !== 32'h11) begin bad++; $display("[TB] FAIL basic_wb_data: got %h want 11", WB_WriteData); end
    total++; if (WB_Count !== 16'd0) begin bad++; $display("[TB] FAIL basic_count_pre: got %0d want 0", WB_Count); end
    tick();
    total++; if (WB_Count !== 16'd1) begin bad++; $display("[TB] FAIL basic_count: got %0d want 1", WB_Count); end
    total++; if (WB_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain: got %b want 0", WB_RegWre); end
  endtask

  task automatic test_load_path();
    setEx(5'd4, 32'h100, 1'b1);
    tick();
    clearEx();
    MEM_ReadData = 32'hCAFE;
    total++; if (MEM_MemToReg !== 1'b1) begin bad++; $display("[TB] FAIL load_mem_flag: got %b want 1", MEM_MemToReg); end
    tick();
    MEM_ReadData = 32'h0;
    total++; if (WB_WriteData !== 32'hCAFE) begin bad++; $display("[TB] FAIL load_wb_data: got %h want cafe", WB_WriteData); end
    total++; if (WB_WriteReg !== 5'd4) begin bad++; $display("[TB] FAIL load_wb_reg: got %0d want 4", WB_WriteReg); end
    tick();
    total++; if (WB_Count !== 16'd2) begin bad++; $display("[TB] FAIL load_count: got %0d want 2", WB_Count); end
  endtask

  task automatic test_zero_register();
    setEx(5'd0, 32'h55, 1'b0);
    tick();
    clearEx();
    total++; if (MEM_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL zero_mem_wre: got %b want 0", MEM_RegWre); end
    tick();
    total++; if (WB_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL zero_wb_wre: got %b want 0", WB_RegWre); end
    tick();
    total++; if (WB_Count !== 16'd2) begin bad++; $display("[TB] FAIL zero_count: got %0d want 2", WB_Count); end
  endtask

  task automatic test_hold();
    setEx(5'd7, 32'h77, 1'b0);
    tick();
    setEx(5'd8, 32'h88, 1'b0);
    tick();
    Hold = 1;
    setEx(5'd9, 32'h99, 1'b0);
    repeat (3) tick();
    total++; if ({MEM_RegWre, MEM_WriteReg} !== {1'b1, 5'd8}) begin bad++; $display("[TB] FAIL hold_mem_tag: got %b/%0d want 1/8", MEM_RegWre, MEM_WriteReg); end
    total++; if (MEM_ALUResult !== 32'h88) begin bad++; $display("[TB] FAIL hold_mem_data: got %h want 88", MEM_ALUResult); end
    total++; if ({WB_RegWre, WB_WriteReg} !== {1'b1, 5'd7}) begin bad++; $display("[TB] FAIL hold_wb_tag: got %b/%0d want 1/7", WB_RegWre, WB_WriteReg); end
    total++; if (WB_WriteData !== 32'h77) begin bad++; $display("[TB] FAIL hold_wb_data: got %h want 77", WB_WriteData); end
    total++; if (WB_Count !== 16'd2) begin bad++; $display("[TB] FAIL hold_count: got %0d want 2", WB_Count); end
    Hold = 0;
    clearEx();
    tick();
    total++; if (WB_WriteReg !== 5'd8 || WB_Count !== 16'd3) begin bad++; $display("[TB] FAIL hold_release: got reg %0d cnt %0d want 8/3", WB_WriteReg, WB_Count); end
  endtask

  task automatic test_flush_hold();
    setEx(5'd10, 32'hAA, 1'b0);
    tick();
    setEx(5'd11, 32'hBB, 1'b0);
    tick();
    Hold = 1; Flush = 1;
    setEx(5'd12, 32'hCC, 1'b0);
    tick();
    total++; if ({MEM_RegWre, MEM_WriteReg, MEM_MemToReg} !== 7'd0 || MEM_ALUResult !== 32'd0) begin bad++; $display("[TB] FAIL flushhold_mem: got wre %b reg %0d data %h want bubble", MEM_RegWre, MEM_WriteReg, MEM_ALUResult); end
    total++; if ({WB_RegWre, WB_WriteReg} !== {1'b1, 5'd10} || WB_WriteData !== 32'hAA) begin bad++; $display("[TB] FAIL flushhold_wb: got %b/%0d/%h want 1/10/aa", WB_RegWre, WB_WriteReg, WB_WriteData); end
    total++; if (WB_Count !== 16'd4) begin bad++; $display("[TB] FAIL flushhold_count: got %0d want 4", WB_Count); end
    Hold = 0; Flush = 0;
    setEx(5'd13, 32'hDD, 1'b0);
    tick();
    Flush = 1;
    setEx(5'd14, 32'hEE, 1'b0);
    tick();
    Flush = 0;
    clearEx();
    total++; if (MEM_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL flush_mem_wre: got %b want 0", MEM_RegWre); end
    total++; if ({WB_RegWre, WB_WriteReg} !== {1'b1, 5'd13} || WB_WriteData !== 32'hDD) begin bad++; $display("[TB] FAIL flush_wb_passes: got %b/%0d/%h want 1/13/dd", WB_RegWre, WB_WriteReg, WB_WriteData); end
    tick();
    total++; if (WB_Count !== 16'd6 || WB_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL flush_count: got %0d/%b want 6/0", WB_Count, WB_RegWre); end
  endtask

  task automatic test_load_use();
    setEx(5'd5, 32'h0, 1'b1);
    ID_rs = 5'd0; ID_rt = 5'd5; #1;
    total++; if (LoadUse_Stall !== LU_ON) begin bad++; $display("[TB] FAIL lu_rt_match: got %b want %b", LoadUse_Stall, LU_ON); end
    ID_rs = 5'd6; ID_rt = 5'd7; #1;
    total++; if (LoadUse_Stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_no_match: got %b want 0", LoadUse_Stall); end
    ID_rs = 5'd5; ID_rt = 5'd0; Hold = 1; #1;
    total++; if (LoadUse_Stall !== LU_ON) begin bad++; $display("[TB] FAIL lu_rs_match_hold: got %b want %b", LoadUse_Stall, LU_ON); end
    Hold = 0; EX_MemToReg = 0; #1;
    total++; if (LoadUse_Stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_not_load: got %b want 0", LoadUse_Stall); end
    setEx(5'd0, 32'h0, 1'b1);
    ID_rs = 5'd0; ID_rt = 5'd0; #1;
    total++; if (LoadUse_Stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_zero_reg: got %b want 0", LoadUse_Stall); end
    clearEx();
  endtask

  task automatic test_reset_midstream();
    setEx(5'd3, 32'h33, 1'b0);
    tick();
    setEx(5'd4, 32'h44, 1'b0);
    tick();
    Hold = 1;
    #2;
    Reset = 0;
    #1;
    total++; if ({MEM_RegWre, MEM_WriteReg, MEM_ALUResult} !== 38'd0) begin bad++; $display("[TB] FAIL midreset_mem: got %b/%0d/%h want 0", MEM_RegWre, MEM_WriteReg, MEM_ALUResult); end
    total++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== 38'd0) begin bad++; $display("[TB] FAIL midreset_wb: got %b/%0d/%h want 0", WB_RegWre, WB_WriteReg, WB_WriteData); end
    total++; if (WB_Count !== 16'd0) begin bad++; $display("[TB] FAIL midreset_count: got %0d want 0", WB_Count); end
    tick();
    total++; if (MEM_RegWre !== 1'b0) begin bad++; $display("[TB] FAIL midreset_held: got %b want 0", MEM_RegWre); end
    Hold = 0;
    clearEx();
    Reset = 1;
  endtask

  task automatic test_saturation();
    setEx(5'd1, 32'h1, 1'b0);
    repeat (65536) tick();
    total++; if (WB_Count !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_preload: got %h want fffe", WB_Count); end
    tick();
    total++; if (WB_Count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_reach: got %h want ffff", WB_Count); end
    repeat (5) tick();
    total++; if (WB_Count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_stick: got %h want ffff", WB_Count); end
    clearEx();
  endtask

  initial begin
    test_reset();
    test_basic_advance();
    test_load_path();
    test_zero_register();
    test_hold();
    test_flush_hold();
    test_load_use();
    test_reset_midstream();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
